// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, per-item prices, vend pulse and greedy change payout.
// Optional idle-credit refund timeout is compiled in when VEND_TIMEOUT_EN is defined.
module vending_machine_multi #(
  parameter int NUM_ITEMS = 4,
  parameter int PRICE_W = 6,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] ITEM_PRICES = {6'd8, 6'd6, 6'd4, 6'd3},
  parameter int CREDIT_W = 6,
  parameter int MAX_CREDIT = 15,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_valid,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    item,
  output logic [1:0]          change,
  output logic                coin_reject,
  output logic                deny,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // One extra bit over the widest operand so sums and compares never wrap.
  localparam int AW = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 1;

  generate
    if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max_credit
      $error("MAX_CREDIT must be below 2**CREDIT_W");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } state_t;

  state_t              state_reg;
  logic [CREDIT_W-1:0] credit_reg;
  logic                out_reg;
  logic [SEL_W-1:0]    item_reg;
  logic [1:0]          change_reg;
  logic                coin_reject_reg;
  logic                deny_reg;
  logic                busy_reg;

  logic [NUM_ITEMS-1:0] sel_hit;
  logic [PRICE_W-1:0]   price_term [NUM_ITEMS];
  logic [PRICE_W-1:0]   price_sel;
  logic                 sel_ok;
  logic [2:0]           coin_val;
  logic [AW-1:0]        credit_ext;
  logic [AW-1:0]        coin_sum;
  logic                 coin_fits;
  logic                 coin_present;
  logic                 coin_accept;
  logic                 can_buy;
  logic                 avail;
  logic [1:0]           pay_code;
  logic [2:0]           pay_amt;
  logic                 timeout_hit;
  logic                 refund_now;

  // Price lookup as a one-hot mux so an out-of-range select simply finds no match.
  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
    assign sel_hit[gi]    = (sel == SEL_W'(gi));
    assign price_term[gi] = sel_hit[gi] ? ITEM_PRICES[gi*PRICE_W +: PRICE_W] : '0;
  end

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      price_sel = price_sel | price_term[i];
    end
  end

  assign sel_ok = |sel_hit;

  always_comb begin
    coin_val = 3'd0;
    case (in)
      2'b01:   coin_val = 3'd1;
      2'b10:   coin_val = 3'd2;
      2'b11:   coin_val = 3'd4;
      default: coin_val = 3'd0;
    endcase
  end

  assign credit_ext   = {{(AW-CREDIT_W){1'b0}}, credit_reg};
  assign coin_sum     = credit_ext + AW'(coin_val);
  assign coin_fits    = (coin_sum <= AW'(MAX_CREDIT));
  assign coin_present = (in != 2'b00);
  assign avail        = (state_reg == S_IDLE) || (state_reg == S_CREDIT);
  assign coin_accept  = coin_present && avail && !sel_valid && !cancel && coin_fits;
  assign can_buy      = sel_ok && (credit_ext >= AW'(price_sel));

  // Largest coin that does not exceed the credit still owed.
  always_comb begin
    pay_code = 2'b01;
    pay_amt  = 3'd1;
    if (credit_ext >= AW'(4)) begin
      pay_code = 2'b11;
      pay_amt  = 3'd4;
    end else if (credit_ext >= AW'(2)) begin
      pay_code = 2'b10;
      pay_amt  = 3'd2;
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt_reg;

  assign timeout_hit = (state_reg == S_CREDIT) && !cancel && !sel_valid && !coin_accept &&
                       (tcnt_reg == TCW'(TIMEOUT_CYCLES - 1));

  // Counts consecutive uneventful cycles spent holding credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_reg <= '0;
    end else if ((state_reg == S_CREDIT) && !cancel && !sel_valid && !coin_accept && !timeout_hit) begin
      tcnt_reg <= tcnt_reg + TCW'(1);
    end else begin
      tcnt_reg <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign refund_now = (state_reg == S_CREDIT) && (cancel || timeout_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      credit_reg      <= '0;
      out_reg         <= 1'b0;
      item_reg        <= '0;
      change_reg      <= 2'b00;
      coin_reject_reg <= 1'b0;
      deny_reg        <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      out_reg         <= 1'b0;
      item_reg        <= '0;
      change_reg      <= 2'b00;
      deny_reg        <= 1'b0;
      coin_reject_reg <= coin_present && !coin_accept;
      case (state_reg)
        S_IDLE, S_CREDIT: begin
          if (refund_now) begin
            // The first change coin goes out on the same edge that enters CHANGE.
            state_reg  <= S_CHANGE;
            busy_reg   <= 1'b1;
            change_reg <= pay_code;
            credit_reg <= credit_reg - CREDIT_W'(pay_amt);
          end else if (sel_valid) begin
            if (can_buy) begin
              state_reg  <= S_VEND;
              busy_reg   <= 1'b1;
              credit_reg <= credit_reg - CREDIT_W'(price_sel);
              out_reg    <= 1'b1;
              item_reg   <= sel;
            end else begin
              deny_reg <= 1'b1;
            end
          end else if (coin_accept) begin
            credit_reg <= credit_reg + CREDIT_W'(coin_val);
            state_reg  <= S_CREDIT;
          end
        end
        S_VEND, S_CHANGE: begin
          if (credit_reg != '0) begin
            state_reg  <= S_CHANGE;
            busy_reg   <= 1'b1;
            change_reg <= pay_code;
            credit_reg <= credit_reg - CREDIT_W'(pay_amt);
          end else begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign out         = out_reg;
  assign item        = item_reg;
  assign change      = change_reg;
  assign coin_reject = coin_reject_reg;
  assign deny        = deny_reg;
  assign credit      = credit_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Testbench for vending_machine_multi: directed scenarios plus random traffic against a
// transaction-level model that precomputes each refund as a queue of greedy change coins.
module tb_vending_machine_multi;

  localparam int NUM_ITEMS  = 4;
  localparam int SEL_W      = 2;
  localparam int CREDIT_W   = 6;
  localparam int MAX_CREDIT = 15;
  localparam int TIMEOUT    = 10;
  localparam int PRICE [4]  = '{3, 4, 6, 8};

  typedef struct packed {
    logic [1:0] c;
    logic [1:0] s;
    logic       v;
    logic       x;
  } stim_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          in = 2'b00;
  logic [SEL_W-1:0]    sel = '0;
  logic                sel_valid = 1'b0;
  logic                cancel = 1'b0;
  logic                out;
  logic [SEL_W-1:0]    item;
  logic [1:0]          change;
  logic                coin_reject;
  logic                deny;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 = taking coins/selects, 1 = vend cycle, 2 = paying change.
  int m_credit;
  int m_phase;
  int m_idle;
  int m_coins[$];
  logic [13:0] exp_v;
  logic [13:0] obs_v;

  vending_machine_multi #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .sel_valid(sel_valid), .cancel(cancel),
    .out(out), .item(item), .change(change), .coin_reject(coin_reject), .deny(deny),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input int c, input int s, input int v, input int x);
    stim_t t;
    t.c = 2'(c);
    t.s = 2'(s);
    t.v = 1'(v);
    t.x = 1'(x);
    return t;
  endfunction

  function automatic string fmt(input logic [13:0] v);
    return $sformatf("out=%b item=%0d change=%b rej=%b deny=%b credit=%0d busy=%b",
                     v[13], v[12:11], v[10:9], v[8], v[7], v[6:1], v[0]);
  endfunction

  task automatic model_reset();
    m_credit = 0;
    m_phase  = 0;
    m_idle   = 0;
    m_coins.delete();
    exp_v = '0;
  endtask

  task automatic pay_next(output logic [1:0] chg);
    int v;
    v = m_coins.pop_front();
    m_credit -= v;
    chg = (v == 4) ? 2'b11 : (v == 2) ? 2'b10 : 2'b01;
  endtask

  task automatic start_payout(output logic [1:0] chg);
    int rem;
    rem = m_credit;
    m_coins.delete();
    while (rem > 0) begin
      if (rem >= 4) begin m_coins.push_back(4); rem -= 4; end
      else if (rem >= 2) begin m_coins.push_back(2); rem -= 2; end
      else begin m_coins.push_back(1); rem -= 1; end
    end
    m_phase = 2;
    m_idle  = 0;
    pay_next(chg);
  endtask

  task automatic model_step(input stim_t t);
    int val;
    int s;
    bit accepted;
    logic e_out, e_rej, e_deny;
    logic [1:0] e_item, e_chg;
    e_out = 0; e_rej = 0; e_deny = 0; e_item = 0; e_chg = 0;
    accepted = 0;
    s = int'(t.s);
    val = (t.c == 2'd1) ? 1 : (t.c == 2'd2) ? 2 : (t.c == 2'd3) ? 4 : 0;
    case (m_phase)
      0: begin
        if (t.x && m_credit > 0) begin
          start_payout(e_chg);
        end else if (t.v) begin
          m_idle = 0;
          if (s < NUM_ITEMS && m_credit >= PRICE[s]) begin
            m_credit -= PRICE[s];
            e_out  = 1;
            e_item = t.s;
            m_phase = 1;
          end else begin
            e_deny = 1;
          end
        end else if (val > 0 && !t.x && m_credit + val <= MAX_CREDIT) begin
          m_credit += val;
          accepted = 1;
          m_idle = 0;
        end else if (m_credit > 0) begin
`ifdef VEND_TIMEOUT_EN
          m_idle++;
          if (m_idle == TIMEOUT) start_payout(e_chg);
`endif
        end else begin
          m_idle = 0;
        end
      end
      1: begin
        if (m_credit > 0) start_payout(e_chg);
        else m_phase = 0;
      end
      default: begin
        if (m_coins.size() > 0) pay_next(e_chg);
        else m_phase = 0;
      end
    endcase
    e_rej = (val > 0) && !accepted;
    exp_v = {e_out, e_item, e_chg, e_rej, e_deny, m_credit[5:0], (m_phase != 0)};
  endtask

  task automatic cycle(input stim_t t);
    @(negedge clk);
    in = t.c;
    sel = t.s;
    sel_valid = t.v;
    cancel = t.x;
    model_step(t);
    @(posedge clk);
    #1;
    obs_v = {out, item, change, coin_reject, deny, credit, busy};
  endtask

  task automatic test_reset();
    rst = 1'b0; in = 2'b00; sel = '0; sel_valid = 1'b0; cancel = 1'b0;
    model_reset();
    #12;
    obs_v = {out, item, change, coin_reject, deny, credit, busy};
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL reset: got {%s} required {%s}", fmt(obs_v), fmt(exp_v));
    end
    @(negedge clk);
    rst = 1'b1;
    $display("reset: checked outputs held at zero");
  endtask

  task automatic test_basic_vend();
    stim_t seq [6];
    seq = '{st(1,0,0,0), st(1,0,0,0), st(1,0,0,0), st(0,0,1,0), st(0,0,0,0), st(0,0,0,0)};
    foreach (seq[i]) begin
      cycle(seq[i]);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL basic_vend step %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
      if (i == 3) begin
        n_cmp++;
        if ({out, item, credit} !== {1'b1, 2'd0, 6'd0}) begin
          n_bad++;
          $display("FAIL basic_vend_pulse: got out=%b item=%0d credit=%0d required out=1 item=0 credit=0", out, item, credit);
        end
      end
      $display("basic_vend step %0d: %s", i, fmt(obs_v));
    end
  endtask

  task automatic test_vend_change();
    stim_t seq [5];
    seq = '{st(3,0,0,0), st(3,0,0,0), st(0,1,1,0), st(0,0,0,0), st(0,0,0,0)};
    foreach (seq[i]) begin
      cycle(seq[i]);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL vend_change step %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
      if (i == 3) begin
        n_cmp++;
        if ({change, credit, busy} !== {2'b11, 6'd0, 1'b1}) begin
          n_bad++;
          $display("FAIL vend_change_coin: got change=%b credit=%0d busy=%b required change=11 credit=0 busy=1", change, credit, busy);
        end
      end
      $display("vend_change step %0d: %s", i, fmt(obs_v));
    end
  endtask

  task automatic test_deny_cancel();
    stim_t seq [5];
    seq = '{st(2,0,0,0), st(0,2,1,0), st(0,0,0,1), st(0,0,0,0), st(0,0,0,0)};
    foreach (seq[i]) begin
      cycle(seq[i]);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL deny_cancel step %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
      if (i == 1) begin
        n_cmp++;
        if ({deny, credit} !== {1'b1, 6'd2}) begin
          n_bad++;
          $display("FAIL deny_flag: got deny=%b credit=%0d required deny=1 credit=2", deny, credit);
        end
      end
      $display("deny_cancel step %0d: %s", i, fmt(obs_v));
    end
  endtask

  task automatic test_reject();
    stim_t seq [8];
    seq = '{st(3,0,0,0), st(3,0,0,0), st(3,0,0,0), st(3,0,0,0),
            st(2,3,1,0), st(0,0,0,0), st(0,0,0,0), st(0,0,0,0)};
    foreach (seq[i]) begin
      cycle(seq[i]);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL reject step %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
      if (i == 4) begin
        n_cmp++;
        if ({coin_reject, deny, out, item} !== {1'b1, 1'b0, 1'b1, 2'd3}) begin
          n_bad++;
          $display("FAIL select_over_coin: got rej=%b deny=%b out=%b item=%0d required rej=1 deny=0 out=1 item=3", coin_reject, deny, out, item);
        end
      end
      $display("reject step %0d: %s", i, fmt(obs_v));
    end
  endtask

  task automatic test_reset_mid_change();
    stim_t seq [4];
    seq = '{st(3,0,0,0), st(2,0,0,0), st(1,0,0,0), st(0,0,0,1)};
    foreach (seq[i]) begin
      cycle(seq[i]);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL mid_change step %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
      $display("mid_change step %0d: %s", i, fmt(obs_v));
    end
    #2;
    rst = 1'b0; in = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
    model_reset();
    #1;
    obs_v = {out, item, change, coin_reject, deny, credit, busy};
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL async_reset_payout: got {%s} required {%s}", fmt(obs_v), fmt(exp_v));
    end
    $display("mid_change async reset: %s", fmt(obs_v));
    @(negedge clk);
    rst = 1'b1;
    cycle(st(1,0,0,0));
    n_cmp++;
    if (obs_v !== exp_v || credit !== 6'd1) begin
      n_bad++;
      $display("FAIL post_reset_coin: got {%s} required {%s}", fmt(obs_v), fmt(exp_v));
    end
    $display("post_reset_coin: %s", fmt(obs_v));
    cycle(st(0,0,0,1));
    cycle(st(0,0,0,0));
  endtask

  task automatic test_hold();
    cycle(st(2,0,0,0));
    for (int i = 0; i < 20; i++) begin
      cycle(st(0,0,0,0));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL hold cycle %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
    end
`ifndef VEND_TIMEOUT_EN
    n_cmp++;
    if (credit !== 6'd2) begin
      n_bad++;
      $display("FAIL hold_credit: got credit=%0d required credit=2", credit);
    end
`endif
    $display("hold after 20 idle cycles: %s", fmt(obs_v));
    cycle(st(0,0,0,1));
    cycle(st(0,0,0,0));
    cycle(st(0,0,0,0));
  endtask

  task automatic test_max_boundary();
    stim_t seq [13];
    seq = '{st(3,0,0,0), st(3,0,0,0), st(3,0,0,0), st(2,0,0,0), st(1,0,0,0), st(1,0,0,0),
            st(0,0,0,1), st(0,0,0,0), st(0,0,0,0), st(0,0,0,0), st(0,0,0,0), st(0,0,0,0), st(0,0,0,0)};
    foreach (seq[i]) begin
      cycle(seq[i]);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL max_boundary step %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
      if (i == 5) begin
        n_cmp++;
        if ({coin_reject, credit} !== {1'b1, 6'd15}) begin
          n_bad++;
          $display("FAIL max_credit_cap: got rej=%b credit=%0d required rej=1 credit=15", coin_reject, credit);
        end
      end
      $display("max_boundary step %0d: %s", i, fmt(obs_v));
    end
  endtask

  task automatic test_back_to_back();
    stim_t seq [9];
    seq = '{st(0,3,1,0), st(3,0,0,0), st(3,0,0,0), st(0,0,1,0), st(1,0,1,0),
            st(0,0,0,1), st(0,0,0,0), st(0,0,0,0), st(0,0,0,0)};
    foreach (seq[i]) begin
      cycle(seq[i]);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL back_to_back step %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
      $display("back_to_back step %0d: %s", i, fmt(obs_v));
    end
  endtask

  task automatic test_random();
    stim_t t;
    int bad_before;
    bad_before = n_bad;
    for (int i = 0; i < 400; i++) begin
      t.c = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      t.s = 2'($urandom_range(0, 3));
      t.v = ($urandom_range(0, 7) == 0);
      t.x = ($urandom_range(0, 15) == 0);
      cycle(t);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL random cycle %0d: got {%s} required {%s}", i, fmt(obs_v), fmt(exp_v));
      end
    end
    $display("random: 400 cycles, %0d new mismatches", n_bad - bad_before);
  endtask

  initial begin
    test_reset();
    test_basic_vend();
    test_vend_change();
    test_deny_cancel();
    test_reject();
    test_reset_mid_change();
    test_hold();
    test_max_boundary();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the single-product vending machine.
- Sells NUM_ITEMS products, each with its own price, and accumulates credit from a 2-bit coin input.
- Dispenses the selected item when credit covers its price, and supports cancel/refund.
- Pays change back one coin per cycle on the same 2-bit coin encoding. Sits between the coin acceptor front-end and the dispenser/coin-hopper drivers.

Parameters:
- NUM_ITEMS, 4: number of products; select width SEL_W = max(1, $clog2(NUM_ITEMS)).
- PRICE_W, 6: width of one price field, in coin units.
- ITEM_PRICES, {6'd8,6'd6,6'd4,6'd3}: packed prices; item i price at [i*PRICE_W +: PRICE_W]. Defaults: item0=3, item1=4, item2=6, item3=8.
- CREDIT_W, 6: width of the credit register.
- MAX_CREDIT, 15: maximum credit held. Elaboration error if MAX_CREDIT >= 2**CREDIT_W.
- TIMEOUT_CYCLES, 1000: idle-credit refund timeout. Used only with VEND_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- in  input  2  coin code, sampled each cycle: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 4 units
- sel  input  SEL_W  product select
- sel_valid  input  1  one-cycle select strobe
- cancel  input  1  one-cycle refund request
- out  output  1  dispense pulse, one cycle
- item  output  SEL_W  id of the dispensed item; valid while out=1, otherwise 0
- change  output  2  change coin paid this cycle, same encoding as in; 00 = none
- coin_reject  output  1  coin on in returned this cycle (not credited)
- deny  output  1  select refused, insufficient credit or invalid id
- credit  output  CREDIT_W  current credit, for the display
- busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, credit=0, timeout counter=0.
  - out, item, change, coin_reject, deny, busy all 0.
  - Any credit held when reset is asserted is forfeited, including mid-CHANGE. Payout stops immediately.
- All outputs are registered. Responses appear the cycle after the sampled input.
- States:
  - IDLE: credit=0.
  - CREDIT: credit>0, accepting coins.
  - VEND: one cycle, out=1.
  - CHANGE: paying out.
- Coin, in IDLE/CREDIT with no sel_valid/cancel that cycle:
  - If credit+value <= MAX_CREDIT: credit += value, state=CREDIT.
  - Otherwise coin_reject=1 and credit is unchanged.
- Coin in VEND/CHANGE, or in the same cycle as sel_valid/cancel: coin_reject=1 and credit is unchanged. The machine never silently swallows a coin.
- Priority, highest first: cancel, then sel_valid, then coin.
- cancel:
  - In CREDIT: go to CHANGE with the full credit.
  - In IDLE, VEND or CHANGE: ignored.
- sel_valid in IDLE/CREDIT:
  - If sel >= NUM_ITEMS or credit < price[sel]: deny=1 for one cycle, state and credit unchanged.
  - Otherwise: go to VEND, credit -= price[sel], out=1, item=sel for one cycle.
- sel_valid in VEND/CHANGE: ignored. No deny.
- VEND exit: next state is CHANGE if remaining credit > 0, else IDLE.
- CHANGE, one coin per cycle, greedy:
  - credit >= 4: change=11, credit -= 4.
  - credit >= 2: change=10, credit -= 2.
  - Otherwise: change=01, credit -= 1.
  - Enter IDLE in the cycle after credit reaches 0; change=00 there.
- Price 0 item: vends with zero credit from IDLE.
- Arithmetic: comparisons are done at CREDIT_W+1 bits, so there is no wrap-around.
- busy=1 exactly in VEND and CHANGE.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle in CREDIT and clears on any accepted coin, deny or state change.
  - At TIMEOUT_CYCLES, the machine enters CHANGE and refunds the full credit as if cancel had been asserted.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter logic. Credit is held indefinitely in CREDIT.

Test Plan:
- rst=0 then release; in=01 for 3 cycles; sel=0, sel_valid -> credit 1,2,3; out=1, item=0 for one cycle; no change; credit=0; IDLE.
- in=11 twice (credit 8); sel=1 -> out=1, item=1; next cycle change=11; credit=0; then IDLE, busy back to 0.
- in=10 (credit 2); sel=2 -> deny=1, credit stays 2; cancel -> change=10 one cycle, then IDLE.
- in=11 three times (credit 12); in=11 -> coin_reject=1, credit 12. in=10 with sel_valid=1, sel=3 in the same cycle -> coin_reject=1 (select wins); deny=0, out=1, item=3; next cycle change=11.
- credit 7, cancel -> change=11, then drive rst=0 before the next payout -> change=00, credit=0, IDLE immediately. After release, in=01 credits normally.
- With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=10: in=10, then idle 10 cycles -> CHANGE, change=10, credit=0. Without the macro: credit stays 2 after 20 cycles.
